// File: rtl/car_sequencer_pkg.sv
// Shared constants, next-address source encoding and helpers for the microcode CAR sequencer.
package car_sequencer_pkg;

  localparam int unsigned CAR_BITS_DEF     = 6;
  localparam int unsigned INT_CHANNELS_DEF = 2;
  localparam int unsigned STACK_DEPTH_DEF  = 2;
  localparam int unsigned CAR_RESET_DEF    = 0;
  localparam int unsigned CAR_INT0_DEF     = 40;
  localparam int unsigned INT_STRIDE_DEF   = 4;

  typedef enum logic [2:0] {
    SRC_INC,
    SRC_HOLD,
    SRC_INT,
    SRC_NEW,
    SRC_RET
  } car_src_e;

  // Untruncated entry point of interrupt channel k; the caller narrows it to the CAR width.
  function automatic int unsigned int_entry_addr(input int unsigned base,
                                                 input int unsigned stride,
                                                 input int unsigned k);
    return base + stride * k;
  endfunction

endpackage

// File: rtl/car_return_stack.sv
// Micro-subroutine return-address LIFO; flush beats pop, pop beats push, and
// push/pop are ignored when full/empty respectively.
module car_return_stack #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0]             sp_q, sp_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  assign full_c  = (sp_q == SP_W'(DEPTH));
  assign empty_c = (sp_q == '0);

  always_comb begin
    top_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sp_q == SP_W'(i + 1)) top_c = mem_q[i];
    end
  end

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (flush_i) begin
      sp_d = '0;
    end else if (pop_i && !empty_c) begin
      sp_d = sp_q - SP_W'(1);
    end else if (push_i && !full_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (sp_q == SP_W'(i)) mem_d[i] = data_i;
      end
      sp_d = sp_q + SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      mem_q <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/car_sequencer.sv
// Registered control-address sequencer: dispatch/branch/call/return, prioritised
// latched interrupt entry and stall hold, with a bounded micro-return stack.
module car_sequencer
  import car_sequencer_pkg::*;
#(
  parameter int unsigned CAR_BITS     = CAR_BITS_DEF,
  parameter int unsigned INT_CHANNELS = INT_CHANNELS_DEF,
  parameter int unsigned STACK_DEPTH  = STACK_DEPTH_DEF,
  parameter int unsigned CAR_RESET    = CAR_RESET_DEF,
  parameter int unsigned CAR_INT0     = CAR_INT0_DEF,
  parameter int unsigned INT_STRIDE   = INT_STRIDE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    IF,
  input  logic                    Br,
  input  logic                    Call,
  input  logic                    Ret,
  input  logic [CAR_BITS-1:0]     CARnew,
  input  logic [INT_CHANNELS-1:0] INTREQ,
  output logic [INT_CHANNELS-1:0] INTACK,
  output logic [CAR_BITS-1:0]     CAR,
  output logic [CAR_BITS-1:0]     CARnext,
  output logic                    ovf,
  output logic                    unf
);

  logic [CAR_BITS-1:0]     car_q, car_d, car_inc, int_entry, stk_top;
  logic [INT_CHANNELS-1:0] pend_q, pend_d, ack_q, ack_d, int_sel, int_clr;
  logic                    ovf_q, ovf_d, unf_q, unf_d;
  logic                    push, pop, flush, stk_full, stk_empty;
  int unsigned             int_k;
  car_src_e                src;

  assign car_inc = car_q + CAR_BITS'(1);

  // Lowest pending channel wins; the entry address wraps to the CAR width.
  always_comb begin
    int_sel = '0;
    int_k   = 0;
    for (int i = int'(INT_CHANNELS) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        int_sel    = '0;
        int_sel[i] = 1'b1;
        int_k      = i;
      end
    end
    int_entry = CAR_BITS'(int_entry_addr(CAR_INT0, INT_STRIDE, int_k));
  end

  always_comb begin
    src     = SRC_INC;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    int_clr = '0;
    ack_d   = '0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (stall) begin
      src = SRC_HOLD;
    end else if (IF && (|pend_q)) begin
      src     = SRC_INT;
      ack_d   = int_sel;
      int_clr = int_sel;
      flush   = 1'b1;
    end else if (IF) begin
      src = SRC_NEW;
    end else if (Ret) begin
      if (stk_empty) begin
        unf_d = 1'b1;
      end else begin
        src = SRC_RET;
        pop = 1'b1;
      end
    end else if (Call) begin
      src = SRC_NEW;
      if (stk_full) ovf_d = 1'b1;
      else          push  = 1'b1;
    end else if (Br) begin
      src = SRC_NEW;
    end
    // A new request in the same cycle as its acknowledge re-pends the channel.
    pend_d = (pend_q & ~int_clr) | INTREQ;
  end

  always_comb begin
    case (src)
      SRC_HOLD: car_d = car_q;
      SRC_INT:  car_d = int_entry;
      SRC_NEW:  car_d = CARnew;
      SRC_RET:  car_d = stk_top;
      default:  car_d = car_inc;
    endcase
  end

  car_return_stack #(
    .WIDTH (CAR_BITS),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (car_inc),
    .top_c   (stk_top),
    .full_c  (stk_full),
    .empty_c (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      car_q  <= CAR_BITS'(CAR_RESET);
      pend_q <= '0;
      ack_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      car_q  <= car_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign CAR     = car_q;
  assign CARnext = car_d;
  assign INTACK  = ack_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Scenario bench for car_sequencer: stimulus tables with expected CAR/INTACK/flags per cycle.
module tb_car_sequencer;

  logic       clk = 1'b0;
  logic       rst, stall, ifv, br, call, ret;
  logic [5:0] carnew, car, car_next;
  logic [1:0] intreq, intack;
  logic       ovf, unf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic       rst, stall, ifv, br, call, ret;
    logic [5:0] nw;
    logic [1:0] rq;
    logic [5:0] car;
    logic [1:0] ack;
    logic       ovf, unf;
  } step_t;

  step_t sb[$];

  always #5 clk = ~clk;

  car_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .IF      (ifv),
    .Br      (br),
    .Call    (call),
    .Ret     (ret),
    .CARnew  (carnew),
    .INTREQ  (intreq),
    .INTACK  (intack),
    .CAR     (car),
    .CARnext (car_next),
    .ovf     (ovf),
    .unf     (unf)
  );

  function automatic step_t mk(input string name, input logic r, s, f, b, c, rt,
                               input logic [5:0] nw, input logic [1:0] rq,
                               input logic [5:0] ecar, input logic [1:0] eack,
                               input logic eo, eu);
    step_t t;
    t.name = name; t.rst = r; t.stall = s; t.ifv = f; t.br = b; t.call = c; t.ret = rt;
    t.nw = nw; t.rq = rq; t.car = ecar; t.ack = eack; t.ovf = eo; t.unf = eu;
    return t;
  endfunction

  task automatic apply(input step_t s);
    rst = s.rst; stall = s.stall; ifv = s.ifv; br = s.br;
    call = s.call; ret = s.ret; carnew = s.nw; intreq = s.rq;
  endtask

  task automatic test_reset();
    step_t e;
    apply(mk("reset", 1, 0, 0, 0, 0, 0, 6'd0, 2'b00, 6'd0, 2'b00, 0, 0));
    sb.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 6'd0, 2'b00, 6'd0, 2'b00, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (car !== e.car || intack !== e.ack || ovf !== e.ovf || unf !== e.unf) begin
      n_bad++;
      $display("FAIL %s: got CAR=%0d INTACK=%b ovf=%b unf=%b, want CAR=%0d INTACK=%b ovf=%b unf=%b",
               e.name, car, intack, ovf, unf, e.car, e.ack, e.ovf, e.unf);
    end
  endtask

  task automatic test_wrap();
    step_t s, e;
    for (int i = 0; i < 64; i++) begin
      s = mk($sformatf("wrap%0d", i), 0, 0, 0, 0, 0, 0, 6'd0, 2'b00, 6'(i + 1), 2'b00, 0, 0);
      apply(s);
      sb.push_back(s);
      #1;
      n_cmp++;
      if (car_next !== s.car) begin
        n_bad++;
        $display("FAIL %s CARnext: got %0d, want %0d", s.name, car_next, s.car);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (car !== e.car || intack !== e.ack || ovf !== e.ovf || unf !== e.unf) begin
        n_bad++;
        $display("FAIL %s: got CAR=%0d INTACK=%b ovf=%b unf=%b, want CAR=%0d INTACK=%b ovf=%b unf=%b",
                 e.name, car, intack, ovf, unf, e.car, e.ack, e.ovf, e.unf);
      end
    end
  endtask

  task automatic run_table(input step_t t[$]);
    step_t e;
    foreach (t[i]) begin
      apply(t[i]);
      sb.push_back(t[i]);
      #1;
      if (!t[i].rst) begin
        n_cmp++;
        if (car_next !== t[i].car) begin
          n_bad++;
          $display("FAIL %s CARnext: got %0d, want %0d", t[i].name, car_next, t[i].car);
        end
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (car !== e.car || intack !== e.ack || ovf !== e.ovf || unf !== e.unf) begin
        n_bad++;
        $display("FAIL %s: got CAR=%0d INTACK=%b ovf=%b unf=%b, want CAR=%0d INTACK=%b ovf=%b unf=%b",
                 e.name, car, intack, ovf, unf, e.car, e.ack, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_dispatch();
    step_t t[$];
    for (int i = 1; i <= 5; i++)
      t.push_back(mk($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 6'd0, 2'b00, 6'(i), 2'b00, 0, 0));
    t.push_back(mk("dispatch17", 0, 0, 1, 0, 0, 0, 6'd17, 2'b00, 6'd17, 2'b00, 0, 0));
    t.push_back(mk("branch30",   0, 0, 0, 1, 0, 0, 6'd30, 2'b00, 6'd30, 2'b00, 0, 0));
    t.push_back(mk("inc31",      0, 0, 0, 0, 0, 0, 6'd9,  2'b00, 6'd31, 2'b00, 0, 0));
    run_table(t);
  endtask

  task automatic test_interrupt();
    step_t t[$];
    t.push_back(mk("int_pulse", 0, 0, 0, 0, 0, 0, 6'd9, 2'b11, 6'd32, 2'b00, 0, 0));
    t.push_back(mk("int_ch0",   0, 0, 1, 0, 0, 0, 6'd9, 2'b00, 6'd40, 2'b01, 0, 0));
    t.push_back(mk("int_ch1",   0, 0, 1, 0, 0, 0, 6'd9, 2'b00, 6'd44, 2'b10, 0, 0));
    t.push_back(mk("int_none",  0, 0, 1, 0, 0, 0, 6'd9, 2'b00, 6'd9,  2'b00, 0, 0));
    run_table(t);
  endtask

  task automatic test_stall();
    step_t t[$];
    t.push_back(mk("stall1",     0, 1, 0, 0, 0, 0, 6'd0,  2'b00, 6'd9,  2'b00, 0, 0));
    t.push_back(mk("stall_req",  0, 1, 0, 0, 0, 0, 6'd0,  2'b10, 6'd9,  2'b00, 0, 0));
    t.push_back(mk("stall3",     0, 1, 1, 0, 0, 0, 6'd3,  2'b00, 6'd9,  2'b00, 0, 0));
    t.push_back(mk("stall_rel",  0, 0, 1, 0, 0, 0, 6'd3,  2'b00, 6'd44, 2'b10, 0, 0));
    t.push_back(mk("stall_ack",  0, 1, 1, 0, 0, 0, 6'd3,  2'b00, 6'd44, 2'b00, 0, 0));
    t.push_back(mk("stall_call", 0, 1, 0, 0, 1, 0, 6'd20, 2'b00, 6'd44, 2'b00, 0, 0));
    run_table(t);
  endtask

  task automatic test_call_ret();
    step_t t[$];
    t.push_back(mk("br10",       0, 0, 0, 1, 0, 0, 6'd10, 2'b00, 6'd10, 2'b00, 0, 0));
    t.push_back(mk("call20",     0, 0, 0, 0, 1, 0, 6'd20, 2'b00, 6'd20, 2'b00, 0, 0));
    t.push_back(mk("call50",     0, 0, 0, 0, 1, 0, 6'd50, 2'b00, 6'd50, 2'b00, 0, 0));
    t.push_back(mk("call60_ovf", 0, 0, 0, 0, 1, 0, 6'd60, 2'b00, 6'd60, 2'b00, 1, 0));
    t.push_back(mk("stall_ret",  0, 1, 0, 0, 0, 1, 6'd0,  2'b00, 6'd60, 2'b00, 1, 0));
    t.push_back(mk("ret21",      0, 0, 0, 0, 0, 1, 6'd0,  2'b00, 6'd21, 2'b00, 1, 0));
    t.push_back(mk("ret11",      0, 0, 0, 0, 0, 1, 6'd0,  2'b00, 6'd11, 2'b00, 1, 0));
    t.push_back(mk("ret_unf",    0, 0, 0, 0, 0, 1, 6'd0,  2'b00, 6'd12, 2'b00, 1, 1));
    run_table(t);
  endtask

  task automatic test_simultaneous();
    step_t t[$];
    t.push_back(mk("sim_reset",   1, 0, 0, 0, 0, 0, 6'd0,  2'b00, 6'd0,  2'b00, 0, 0));
    t.push_back(mk("br32",        0, 0, 0, 1, 0, 0, 6'd32, 2'b00, 6'd32, 2'b00, 0, 0));
    t.push_back(mk("call5",       0, 0, 0, 0, 1, 0, 6'd5,  2'b00, 6'd5,  2'b00, 0, 0));
    t.push_back(mk("inc6",        0, 0, 0, 0, 0, 0, 6'd0,  2'b00, 6'd6,  2'b00, 0, 0));
    t.push_back(mk("inc7",        0, 0, 0, 0, 0, 0, 6'd0,  2'b00, 6'd7,  2'b00, 0, 0));
    t.push_back(mk("call_ret",    0, 0, 0, 0, 1, 1, 6'd50, 2'b00, 6'd33, 2'b00, 0, 0));
    t.push_back(mk("ret_empty",   0, 0, 0, 0, 0, 1, 6'd0,  2'b00, 6'd34, 2'b00, 0, 1));
    t.push_back(mk("ret_br",      0, 0, 0, 1, 0, 1, 6'd20, 2'b00, 6'd35, 2'b00, 0, 1));
    t.push_back(mk("call10",      0, 0, 0, 0, 1, 0, 6'd10, 2'b00, 6'd10, 2'b00, 0, 1));
    t.push_back(mk("req0",        0, 0, 0, 0, 0, 0, 6'd0,  2'b01, 6'd11, 2'b00, 0, 1));
    t.push_back(mk("int_flush",   0, 0, 1, 0, 0, 0, 6'd0,  2'b00, 6'd40, 2'b01, 0, 1));
    t.push_back(mk("ret_flushed", 0, 0, 0, 0, 0, 1, 6'd0,  2'b00, 6'd41, 2'b00, 0, 1));
    run_table(t);
  endtask

  task automatic test_reset_midop();
    step_t t[$];
    t.push_back(mk("mid_reset",  1, 0, 0, 0, 0, 0, 6'd0,  2'b00, 6'd0,  2'b00, 0, 0));
    t.push_back(mk("mid_call20", 0, 0, 0, 0, 1, 0, 6'd20, 2'b00, 6'd20, 2'b00, 0, 0));
    t.push_back(mk("mid_call30", 0, 0, 0, 0, 1, 0, 6'd30, 2'b00, 6'd30, 2'b00, 0, 0));
    t.push_back(mk("mid_call40", 0, 0, 0, 0, 1, 0, 6'd40, 2'b00, 6'd40, 2'b00, 1, 0));
    t.push_back(mk("mid_req0",   0, 0, 0, 0, 0, 0, 6'd0,  2'b01, 6'd41, 2'b00, 1, 0));
    t.push_back(mk("rst_mid",    1, 0, 1, 0, 1, 0, 6'd5,  2'b00, 6'd0,  2'b00, 0, 0));
    t.push_back(mk("if_after",   0, 0, 1, 0, 0, 0, 6'd12, 2'b00, 6'd12, 2'b00, 0, 0));
    t.push_back(mk("ret_after",  0, 0, 0, 0, 0, 1, 6'd0,  2'b00, 6'd13, 2'b00, 0, 1));
    run_table(t);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ifv = 1'b0; br = 1'b0;
    call = 1'b0; ret = 1'b0; carnew = '0; intreq = '0;
    test_reset();
    test_wrap();
    test_dispatch();
    test_interrupt();
    test_stall();
    test_call_ret();
    test_simultaneous();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
